// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: serializer state
// encoding and the frame-length helper.
// Optional feature macro: UART_TX_PARITY_EN (adds one parity bit per frame).
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } tx_state_t;
`endif

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_w, input int stop_bits);
    return 1 + data_w + PARITY_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for the UART transmit buffer.
// Read data is the registered head entry, so a character written on one
// edge is visible on dout from the next cycle. Full/empty derive from the
// occupancy counter; pointers wrap naturally (depth is a power of two).
module uart_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic                          rd,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_do_wr;
  logic              w_do_rd;

  assign full    = (r_level == LW'(FIFO_DEPTH));
  assign empty   = (r_level == '0);
  assign w_do_wr = wr && !full;
  assign w_do_rd = rd && !empty;
  assign dout    = r_mem[r_rd_ptr];
  assign level   = r_level;

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a FIFO in front of a baud-tick driven
// serializer (start, LSB-first data, optional parity, stop bits).
// Optional feature macro: UART_TX_PARITY_EN adds input parity_odd and a
// parity bit after the data bits.
//
// Handshake: a character is taken on a rising edge where s_valid && s_ready;
// s_ready is !full from registered FIFO state, and a producer holding
// s_valid while s_ready is low simply waits (nothing dropped, nothing repeated).
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output tx_state_t                     o_dbg_state
);

  localparam int FRAME_LEN = frame_bits(DATA_W, STOP_BITS);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  tx_state_t         r_state, w_state_n;
  logic [DATA_W-1:0] r_shift, w_shift_n;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_n;
  logic              r_tx,    w_tx_n;
`ifdef UART_TX_PARITY_EN
  logic              r_par,   w_par_n;
`endif

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_fifo_dout;

  assign s_ready     = !w_full;
  assign w_push      = s_valid && s_ready;
  assign tx          = r_tx;
  assign busy        = (r_state != IDLE) || !w_empty;
  assign o_dbg_state = r_state;

  uart_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (w_push),
    .rd    (w_pop),
    .din   (s_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // Serializer state register; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_cnt   <= w_cnt_n;
      r_tx    <= w_tx_n;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  // Next-state logic: every transition happens only on a baud tick, and the
  // line value for the new bit is registered on that same edge.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_cnt_n   = r_cnt;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_n   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_tx_n = 1'b1;
        if (baud_tick && !w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_fifo_dout;
          w_state_n = START;
          w_tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_par_n   = (^w_fifo_dout) ^ parity_odd;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          w_state_n = DATA;
          w_tx_n    = r_shift[0];
          w_shift_n = r_shift >> 1;
          w_cnt_n   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_n = PARITY;
            w_tx_n    = r_par;
`else
            w_state_n = STOP;
            w_tx_n    = 1'b1;
            w_cnt_n   = '0;
`endif
          end else begin
            w_tx_n    = r_shift[0];
            w_shift_n = r_shift >> 1;
            w_cnt_n   = r_cnt + CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          w_state_n = STOP;
          w_tx_n    = 1'b1;
          w_cnt_n   = '0;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (r_cnt == CNT_W'(STOP_BITS - 1)) begin
            // Last stop bit done: chain straight into the next frame if one waits.
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_shift_n = w_fifo_dout;
              w_state_n = START;
              w_tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
              w_par_n   = (^w_fifo_dout) ^ parity_odd;
`endif
            end else begin
              w_state_n = IDLE;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_n = IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of buffered characters; power of two, at least 2.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port baud_tick, input, 1, one-clk strobe, once per bit period.
REQ-007 SHALL have port s_data, input, DATA_W, character to send.
REQ-008 SHALL have port s_valid, input, 1, s_data is valid.
REQ-009 SHALL have port s_ready, output, 1, buffer can accept a character.
REQ-010 SHALL have port tx, output, 1, serial line; idle high.
REQ-011 SHALL have port busy, output, 1, frame in progress or FIFO non-empty.
REQ-012 SHALL have port level, output, $clog2(FIFO_DEPTH)+1, number of characters stored in the FIFO.

Function
REQ-013 SHALL accept a character on a rising edge where s_valid && s_ready; s_ready = !full, combinational from registered state.
REQ-014 SHALL never drop a character and never duplicate one; s_valid while full stalls the producer.
REQ-015 SHALL make an accepted character poppable on the next cycle (write-to-read latency 1 clk).
REQ-016 SHALL implement serializer FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL stay in IDLE with tx=1 until a baud_tick arrives with the FIFO non-empty.
REQ-018 SHALL, on that tick, pop the head into a shift register and go to START; tx=0 from the next clk.
REQ-019 SHALL advance one bit on each subsequent baud_tick, so every bit lasts exactly one tick period.
REQ-020 SHALL send DATA_W data bits LSB first, then PARITY (only with the macro), then STOP_BITS stop bits at tx=1.
REQ-021 SHALL, at the last stop-bit tick, go to IDLE.
REQ-022 SHALL, when the FIFO is non-empty at that same tick, pop immediately and go to START with no idle gap (back-to-back frames).
REQ-023 SHALL handle push and pop in the same cycle as follows: level unchanged; when full, the push is refused because s_ready=0 that cycle.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH; full/empty come from level, not pointer equality alone.
REQ-025 SHALL ignore baud_tick except at state transitions; multiple ticks never skip bits.

Reset
REQ-026 SHALL, while rst is high: tx=1, state=IDLE, level=0, busy=0, s_ready=1, pointers 0.
REQ-027 SHALL, on rst mid-frame, abort the frame, return tx to 1 asynchronously and discard FIFO contents.
REQ-028 SHALL allow the first accept on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with UART_TX_PARITY_EN defined, add input parity_odd (1 bit, sampled at pop) and send one parity bit after the data bits: odd when parity_odd=1, otherwise even.
REQ-030 SHALL, without UART_TX_PARITY_EN, have no parity_odd port and no PARITY state; frame = 1+DATA_W+STOP_BITS bits.

Structure
REQ-031 SHALL take the serializer state enum and a frame-length constant function from shared package uart_pkg.
REQ-032 SHALL instantiate one sub-module, uart_sync_fifo (parametrised DATA_W and FIFO_DEPTH, ports wr/rd/din/dout/full/empty/level); the serializer FSM is in uart_tx_buf itself.

Verification
REQ-033 SHALL cover this scenario: reset; push 0x55, tick every 16 clk -> tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first, stop), each bit 16 clk.
REQ-034 SHALL cover this scenario: push 0xA3, 0x0F in consecutive clk -> both frames back-to-back with no idle bit; busy falls 1 clk after the last stop tick.
REQ-035 SHALL cover this scenario: FIFO_DEPTH=4, s_valid held with no ticks -> 4 accepts, then s_ready=0, level=4; one frame sent -> exactly one further accept.
REQ-036 SHALL cover this scenario: assert rst during data bit 3 of 0xFF -> tx=1 within the same cycle, level=0; a subsequent push of 0x81 transmits correctly.
REQ-037 SHALL cover this scenario: UART_TX_PARITY_EN with parity_odd=0, send 0x07 -> parity bit 1; parity_odd=1 -> parity bit 0.
REQ-038 SHALL cover this scenario: STOP_BITS=2, DATA_W=7, send 0x7F -> frame of 10 bit periods, last two high.
